// File: rtl/lc3b_types.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc3b_types : shared word/block types and L2 prefetch FSM encoding    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_block;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DEMAND   = 3'd1,
      BUF_HIT  = 3'd2,
      PF_FETCH = 3'd3,
      PF_OFFER = 3'd4
   } l2pf_state_t;

   // Address of the following line; the line index wraps at the top of memory.
   function automatic lc3b_word next_line(input lc3b_word addr, input int unsigned log_bytes);
      lc3b_word idx;
      idx = addr >> log_bytes;
      idx = idx + 16'd1;
      return idx << log_bytes;
   endfunction

endpackage
`default_nettype wire

// File: rtl/l2_prefetch_arbiter_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_prefetch_arbiter_control : arbitration FSM and prefetch flags     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module l2_prefetch_arbiter_control
   import lc3b_types::*;
#(
   parameter int PF_ENABLE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic demand_read,
   input  logic demand_write,
   input  logic line_match,
   input  logic pmem_resp,
   input  logic done_prefetch,
   input  logic no_prefetch,
   output logic sel_demand,
   output logic sel_prefetch,
   output logic load_pf_addr,
   output logic load_buf,
   output logic l2_resp,
   output logic resp_from_buf,
   output logic offer,
   output logic pf_busy
);

   l2pf_state_t state_q, state_d;
   logic        pf_pending_q, pf_pending_d;
   logic        buf_valid_q, buf_valid_d;
   logic        demand, hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         pf_pending_q <= 1'b0;
         buf_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pf_pending_q <= pf_pending_d;
         buf_valid_q  <= buf_valid_d;
      end
   end

   assign demand = demand_read | demand_write;
   assign hit    = demand_read & buf_valid_q & line_match;

   always_comb begin
      state_d       = state_q;
      pf_pending_d  = pf_pending_q;
      buf_valid_d   = buf_valid_q;
      sel_demand    = 1'b0;
      sel_prefetch  = 1'b0;
      load_pf_addr  = 1'b0;
      load_buf      = 1'b0;
      l2_resp       = 1'b0;
      resp_from_buf = 1'b0;
      offer         = 1'b0;
      case (state_q)
         IDLE: begin
            if (demand)            state_d = hit ? BUF_HIT : DEMAND;
            else if (pf_pending_q) state_d = PF_FETCH;
            else if (buf_valid_q)  state_d = PF_OFFER;
         end
         DEMAND: begin
            sel_demand = 1'b1;
            if (pmem_resp) begin
               l2_resp = 1'b1;
               state_d = IDLE;
               if (demand_read) begin
                  if (PF_ENABLE != 0) begin
                     pf_pending_d = 1'b1;
                     buf_valid_d  = 1'b0;
                     load_pf_addr = 1'b1;
                  end
               end else if (line_match) begin
                  // A writeback makes any pending or buffered copy of that line stale.
                  pf_pending_d = 1'b0;
                  buf_valid_d  = 1'b0;
               end
            end
         end
         BUF_HIT: begin
            l2_resp       = 1'b1;
            resp_from_buf = 1'b1;
            buf_valid_d   = 1'b0;
            state_d       = IDLE;
            if (PF_ENABLE != 0) begin
               pf_pending_d = 1'b1;
               load_pf_addr = 1'b1;
            end
         end
         PF_FETCH: begin
            sel_prefetch = 1'b1;
            if (pmem_resp) begin
               load_buf     = 1'b1;
               buf_valid_d  = 1'b1;
               pf_pending_d = 1'b0;
               state_d      = IDLE;
            end
         end
         PF_OFFER: begin
            if (demand) begin
               state_d = hit ? BUF_HIT : DEMAND;
            end else begin
               offer = 1'b1;
               if (done_prefetch | no_prefetch) begin
                  buf_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pf_busy = pf_pending_q | (state_q == PF_FETCH);

endmodule
`default_nettype wire

// File: rtl/l2_prefetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_prefetch_arbiter : next-line prefetcher and pmem arbiter for L2   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module l2_prefetch_arbiter
   import lc3b_types::*;
#(
   parameter int PF_ENABLE      = 1,
   parameter int LOG_LINE_BYTES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         l2_pmem_read,
   input  logic         l2_pmem_write,
   input  logic [15:0]  l2_pmem_address,
   input  logic [127:0] l2_pmem_wdata,
   output logic         l2_pmem_resp,
   output logic [127:0] l2_pmem_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic         pmem_resp,
   input  logic [127:0] pmem_rdata,
   output logic         prefetch_ready,
   output logic         prefetch_busy,
   output logic [15:0]  prefetch_address,
   output logic [127:0] prefetch_wdata,
   input  logic         no_prefetch,
   input  logic         done_prefetch
);

   // pf_addr doubles as the buffered line's address once the fetch lands.
   lc3b_word  pf_addr_q, pf_addr_d;
   lc3b_block buf_data_q, buf_data_d;

   logic line_match;
   logic sel_demand, sel_prefetch, load_pf_addr, load_buf;
   logic l2_resp, resp_from_buf, offer;

   assign line_match = (l2_pmem_address[15:LOG_LINE_BYTES] == pf_addr_q[15:LOG_LINE_BYTES]);

   l2_prefetch_arbiter_control #(
      .PF_ENABLE (PF_ENABLE)
   ) u_control (
      .clk           (clk),
      .reset         (reset),
      .demand_read   (l2_pmem_read),
      .demand_write  (l2_pmem_write),
      .line_match    (line_match),
      .pmem_resp     (pmem_resp),
      .done_prefetch (done_prefetch),
      .no_prefetch   (no_prefetch),
      .sel_demand    (sel_demand),
      .sel_prefetch  (sel_prefetch),
      .load_pf_addr  (load_pf_addr),
      .load_buf      (load_buf),
      .l2_resp       (l2_resp),
      .resp_from_buf (resp_from_buf),
      .offer         (offer),
      .pf_busy       (prefetch_busy)
   );

   always_comb begin
      pf_addr_d  = pf_addr_q;
      buf_data_d = buf_data_q;
      if (load_pf_addr) pf_addr_d  = next_line(l2_pmem_address, LOG_LINE_BYTES);
      if (load_buf)     buf_data_d = pmem_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pf_addr_q  <= '0;
         buf_data_q <= '0;
      end else begin
         pf_addr_q  <= pf_addr_d;
         buf_data_q <= buf_data_d;
      end
   end

   always_comb begin
      pmem_read        = (sel_demand & l2_pmem_read) | sel_prefetch;
      pmem_write       = sel_demand & l2_pmem_write & ~l2_pmem_read;
      pmem_address     = '0;
      pmem_wdata       = '0;
      l2_pmem_rdata    = '0;
      prefetch_address = '0;
      prefetch_wdata   = '0;
      if (sel_prefetch) begin
         pmem_address = pf_addr_q;
      end else if (sel_demand) begin
         pmem_address = l2_pmem_address;
         pmem_wdata   = l2_pmem_wdata;
      end
      if (resp_from_buf)  l2_pmem_rdata = buf_data_q;
      else if (l2_resp)   l2_pmem_rdata = pmem_rdata;
      if (offer) begin
         prefetch_address = pf_addr_q;
         prefetch_wdata   = buf_data_q;
      end
   end

   assign l2_pmem_resp   = l2_resp;
   assign prefetch_ready = offer;

endmodule
`default_nettype wire
